// File: rtl/mvm_stream_if.sv
// Stream bundle for mvm_stream: element input channel plus result output channel.
// The slave modport is the multiplier side; the master modport is the source/consumer side.
interface mvm_stream_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
);
  logic             s_valid;
  logic             s_ready;
  logic [IN_W-1:0]  data_in;
  logic             m_valid;
  logic             m_ready;
  logic [OUT_W-1:0] data_out;
  logic             overflow;

  modport slave (
    input  s_valid, data_in, m_ready,
    output s_ready, m_valid, data_out, overflow
  );

  modport master (
    output s_valid, data_in, m_ready,
    input  s_ready, m_valid, data_out, overflow
  );
endinterface

// File: rtl/mvm_stream.sv
// Streaming M x N matrix-vector multiplier: loads A then x, runs one MAC per cycle
// through a registered-read pipeline, then streams y[r] with per-row overflow flags.
module mvm_stream #(
  parameter int M     = 3,
  parameter int N     = 3,
  parameter int IN_W  = 8,
  parameter int OUT_W = 16,
  parameter int SAT   = 0
) (
  input logic         clk,
  input logic         reset,
  mvm_stream_if.slave bus
);
  localparam int MN = M * N;
  localparam int AW = (MN > 1) ? $clog2(MN) : 1;
  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * IN_W;

  localparam logic [AW-1:0] A_LAST   = AW'(MN - 1);
  localparam logic [AW-1:0] X_LAST   = AW'(N - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(M - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(N - 1);

  localparam logic signed [OUT_W-1:0] ACC_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] ACC_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  localparam logic [1:0] LOAD_A  = 2'd0;
  localparam logic [1:0] LOAD_X  = 2'd1;
  localparam logic [1:0] COMPUTE = 2'd2;
  localparam logic [1:0] OUTPUT  = 2'd3;

  logic [IN_W-1:0]  a_mem [MN];
  logic [IN_W-1:0]  x_mem [N];
  logic [OUT_W-1:0] y_mem [M];
  logic [M-1:0]     ovf_mem;

  logic [1:0]              state_q, state_d;
  logic                    s_ready_q, s_ready_d;
  logic [AW-1:0]           load_cnt_q, load_cnt_d;
  logic                    iss_q, iss_d;
  logic [RW-1:0]           row_q, row_d;
  logic [CW-1:0]           col_q, col_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic                    rd_vld_q, rd_vld_d;
  logic                    rd_first_q, rd_first_d;
  logic                    rd_last_q, rd_last_d;
  logic [RW-1:0]           rd_row_q, rd_row_d;
  logic signed [IN_W-1:0]  a_rd_q, x_rd_q;
  logic signed [OUT_W-1:0] acc_q, acc_d;
  logic                    acc_ovf_q, acc_ovf_d;
  logic [RW-1:0]           out_k_q, out_k_d;
  logic                    m_valid_q, m_valid_d;
  logic [OUT_W-1:0]        data_out_q, data_out_d;
  logic                    overflow_q, overflow_d;

  logic                    in_xfer;
  logic                    row_done;
  logic [RW-1:0]           out_nxt;
  logic signed [PW-1:0]    prod_full;
  logic signed [OUT_W-1:0] prod_ext, acc_base, sum, mac_acc;
  logic                    ovf_base, add_ovf, mac_ovf;

  assign bus.s_ready  = s_ready_q;
  assign bus.m_valid  = m_valid_q;
  assign bus.data_out = data_out_q;
  assign bus.overflow = overflow_q;

  // MAC stage: a first-of-row tag restarts the accumulator, so results never depend on pipeline fill.
  always_comb begin
    prod_full = PW'(a_rd_q) * PW'(x_rd_q);
    prod_ext  = OUT_W'(prod_full);
    acc_base  = rd_first_q ? '0 : acc_q;
    ovf_base  = rd_first_q ? 1'b0 : acc_ovf_q;
    sum       = acc_base + prod_ext;
    add_ovf   = (acc_base[OUT_W-1] == prod_ext[OUT_W-1]) && (sum[OUT_W-1] != acc_base[OUT_W-1]);
    mac_ovf   = ovf_base | add_ovf;
    mac_acc   = sum;
    if (SAT != 0) begin
      if (ovf_base) begin
        mac_acc = acc_base;
      end else if (add_ovf) begin
        mac_acc = prod_ext[OUT_W-1] ? ACC_MIN : ACC_MAX;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    iss_d      = iss_q;
    row_d      = row_q;
    col_d      = col_q;
    addr_d     = addr_q;
    rd_vld_d   = 1'b0;
    rd_first_d = rd_first_q;
    rd_last_d  = rd_last_q;
    rd_row_d   = rd_row_q;
    acc_d      = acc_q;
    acc_ovf_d  = acc_ovf_q;
    out_k_d    = out_k_q;
    m_valid_d  = m_valid_q;
    data_out_d = data_out_q;
    overflow_d = overflow_q;
    out_nxt    = out_k_q + RW'(1);
    in_xfer    = bus.s_valid && s_ready_q;
    row_done   = rd_vld_q && rd_last_q;

    if (rd_vld_q) begin
      acc_d     = mac_acc;
      acc_ovf_d = mac_ovf;
    end

    case (state_q)
      LOAD_A: begin
        if (in_xfer) begin
          if (load_cnt_q == A_LAST) begin
            load_cnt_d = '0;
            state_d    = LOAD_X;
          end else begin
            load_cnt_d = load_cnt_q + AW'(1);
          end
        end
      end
      LOAD_X: begin
        if (in_xfer) begin
          if (load_cnt_q == X_LAST) begin
            load_cnt_d = '0;
            state_d    = COMPUTE;
            iss_d      = 1'b1;
          end else begin
            load_cnt_d = load_cnt_q + AW'(1);
          end
        end
      end
      COMPUTE: begin
        if (iss_q) begin
          rd_vld_d   = 1'b1;
          rd_first_d = (col_q == '0);
          rd_last_d  = (col_q == COL_LAST);
          rd_row_d   = row_q;
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              row_d  = '0;
              addr_d = '0;
              iss_d  = 1'b0;
            end else begin
              row_d  = row_q + RW'(1);
              addr_d = addr_q + AW'(1);
            end
          end else begin
            col_d  = col_q + CW'(1);
            addr_d = addr_q + AW'(1);
          end
        end
        if (row_done && (rd_row_q == ROW_LAST)) begin
          state_d = OUTPUT;
        end
      end
      default: begin
        // First OUTPUT cycle only fetches y[0]; afterwards each transfer fetches the next row.
        if (!m_valid_q) begin
          m_valid_d  = 1'b1;
          data_out_d = y_mem[out_k_q];
          overflow_d = ovf_mem[out_k_q];
        end else if (bus.m_ready) begin
          if (out_k_q == ROW_LAST) begin
            state_d    = LOAD_A;
            out_k_d    = '0;
            m_valid_d  = 1'b0;
            data_out_d = '0;
            overflow_d = 1'b0;
          end else begin
            out_k_d    = out_nxt;
            data_out_d = y_mem[out_nxt];
            overflow_d = ovf_mem[out_nxt];
          end
        end
      end
    endcase

    s_ready_d = (state_d == LOAD_A) || (state_d == LOAD_X);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= LOAD_A;
      s_ready_q  <= 1'b0;
      load_cnt_q <= '0;
      iss_q      <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      addr_q     <= '0;
      rd_vld_q   <= 1'b0;
      rd_first_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_row_q   <= '0;
      acc_q      <= '0;
      acc_ovf_q  <= 1'b0;
      out_k_q    <= '0;
      m_valid_q  <= 1'b0;
      data_out_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_ready_q  <= s_ready_d;
      load_cnt_q <= load_cnt_d;
      iss_q      <= iss_d;
      row_q      <= row_d;
      col_q      <= col_d;
      addr_q     <= addr_d;
      rd_vld_q   <= rd_vld_d;
      rd_first_q <= rd_first_d;
      rd_last_q  <= rd_last_d;
      rd_row_q   <= rd_row_d;
      acc_q      <= acc_d;
      acc_ovf_q  <= acc_ovf_d;
      out_k_q    <= out_k_d;
      m_valid_q  <= m_valid_d;
      data_out_q <= data_out_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage arrays carry no reset; every pass rewrites all locations before they are read.
  always_ff @(posedge clk) begin
    if (in_xfer && (state_q == LOAD_A)) begin
      a_mem[load_cnt_q] <= bus.data_in;
    end
    if (in_xfer && (state_q == LOAD_X)) begin
      x_mem[load_cnt_q[CW-1:0]] <= bus.data_in;
    end
    a_rd_q <= a_mem[addr_q];
    x_rd_q <= x_mem[col_q];
    if (row_done) begin
      y_mem[rd_row_q]   <= mac_acc;
      ovf_mem[rd_row_q] <= mac_ovf;
    end
  end
endmodule

// File: tb/tb_mvm_stream.sv
// Bench for mvm_stream: three instances (3x3 wrap, 3x3 saturate, 2x4 wrap) driven by
// table vectors, random passes against an arithmetic model, and reset-abort sequences.
module tb_mvm_stream;
  logic clk;
  logic reset;
  logic [2:0]  sv;
  logic [2:0]  mr;
  logic [7:0]  din [3];
  logic [2:0]  sr;
  logic [2:0]  mv;
  logic [2:0]  ovf;
  logic [15:0] dout [3];

  int n_checks;
  int n_errors;

  int in_buf [3][16];
  int exp_y  [3][4];
  bit exp_o  [3][4];
  bit out_done [3];

  typedef struct packed {
    logic [1:0]        sel;
    logic [11:0][7:0]  a;
    logic [3:0][7:0]   x;
    logic [2:0][15:0]  y;
    logic [2:0]        ov;
  } vec_t;

  vec_t tbl [5];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    mvm_stream_if #(.IN_W(8), .OUT_W(16)) bus ();
    assign bus.s_valid = sv[gi];
    assign bus.data_in = din[gi];
    assign bus.m_ready = mr[gi];
    assign sr[gi]      = bus.s_ready;
    assign mv[gi]      = bus.m_valid;
    assign ovf[gi]     = bus.overflow;
    assign dout[gi]    = bus.data_out;

    mvm_stream #(
      .M     ((gi == 2) ? 2 : 3),
      .N     ((gi == 2) ? 4 : 3),
      .IN_W  (8),
      .OUT_W (16),
      .SAT   ((gi == 1) ? 1 : 0)
    ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );
  end

  function automatic int nm(input int s);
    return (s == 2) ? 2 : 3;
  endfunction

  function automatic int nn(input int s);
    return (s == 2) ? 4 : 3;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: exact integer dot products, then wrap or clamp-and-freeze on leaving 16-bit range.
  function automatic void model(input int sel);
    int m;
    int n;
    longint acc;
    longint p;
    longint s;
    bit ov;
    bit frz;
    m = nm(sel);
    n = nn(sel);
    for (int r = 0; r < m; r++) begin
      acc = 0;
      ov  = 1'b0;
      frz = 1'b0;
      for (int c = 0; c < n; c++) begin
        p = longint'(in_buf[sel][r*n+c]) * longint'(in_buf[sel][m*n+c]);
        s = acc + p;
        if (frz) continue;
        if (s > 32767 || s < -32768) begin
          ov = 1'b1;
          if (sel == 1) begin
            acc = (p < 0) ? -32768 : 32767;
            frz = 1'b1;
          end else begin
            acc = ((s % 65536) + 65536 + 32768) % 65536 - 32768;
          end
        end else begin
          acc = s;
        end
      end
      exp_y[sel][r] = int'(acc);
      exp_o[sel][r] = ov;
    end
  endfunction

  task automatic load_table(input int k);
    int sel;
    int m;
    int n;
    sel = int'(tbl[k].sel);
    m = nm(sel);
    n = nn(sel);
    for (int i = 0; i < m*n; i++) in_buf[sel][i] = int'($signed(tbl[k].a[i]));
    for (int j = 0; j < n; j++) in_buf[sel][m*n+j] = int'($signed(tbl[k].x[j]));
    for (int r = 0; r < m; r++) begin
      exp_y[sel][r] = int'($signed(tbl[k].y[r]));
      exp_o[sel][r] = tbl[k].ov[r];
    end
  endtask

  task automatic send_inputs(input int sel, input bit rnd, input bit junk);
    int total;
    int w;
    total = nm(sel) * nn(sel) + nn(sel);
    for (int i = 0; i < total; i++) begin
      @(negedge clk);
      if (rnd) begin
        while ($urandom_range(0, 2) == 0) begin
          sv[sel] = 1'b0;
          @(negedge clk);
        end
      end
      sv[sel]  = 1'b1;
      din[sel] = 8'(in_buf[sel][i]);
      w = 0;
      while (!sr[sel] && w < 200) begin
        @(negedge clk);
        w++;
      end
      chk("s_ready_wait", longint'(sr[sel]), 1);
      @(posedge clk);
    end
    @(negedge clk);
    sv[sel] = 1'b0;
    chk("s_ready_drop_after_load", longint'(sr[sel]), 0);
    if (junk) begin
      sv[sel]  = 1'b1;
      din[sel] = 8'($urandom);
      while (1) begin
        @(negedge clk);
        if (out_done[sel]) break;
        sv[sel]  = 1'b1;
        din[sel] = 8'($urandom);
      end
    end
  endtask

  task automatic collect(input int sel, input bit rnd);
    int got;
    int cyc;
    bit held;
    logic [15:0] hv;
    logic hov;
    got  = 0;
    cyc  = 0;
    held = 1'b0;
    hv   = '0;
    hov  = 1'b0;
    while (got < nm(sel) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (held) begin
        chk("stall_m_valid", longint'(mv[sel]), 1);
        chk("stall_data_out", longint'($signed(dout[sel])), longint'($signed(hv)));
        chk("stall_overflow", longint'(ovf[sel]), longint'(hov));
      end
      if (!mv[sel]) chk("overflow_idle", longint'(ovf[sel]), 0);
      mr[sel] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mv[sel] && mr[sel]) begin
        chk($sformatf("y[%0d]_dut%0d", got, sel), longint'($signed(dout[sel])), longint'(exp_y[sel][got]));
        chk($sformatf("ovf[%0d]_dut%0d", got, sel), longint'(ovf[sel]), longint'(exp_o[sel][got]));
        $display("dut%0d out[%0d] = %0d ovf=%0d", sel, got, $signed(dout[sel]), ovf[sel]);
        got++;
        held = 1'b0;
        if (got == nm(sel)) begin
          out_done[sel] = 1'b1;
          sv[sel] = 1'b0;
        end
      end else begin
        held = mv[sel];
        hv   = dout[sel];
        hov  = ovf[sel];
      end
    end
    chk("output_count", got, nm(sel));
    out_done[sel] = 1'b1;
    sv[sel] = 1'b0;
    @(negedge clk);
    chk("m_valid_after_pass", longint'(mv[sel]), 0);
    chk("s_ready_after_pass", longint'(sr[sel]), 1);
    chk("overflow_after_pass", longint'(ovf[sel]), 0);
  endtask

  task automatic run_pass(input int sel, input bit rnd, input bit junk);
    out_done[sel] = 1'b0;
    fork
      send_inputs(sel, rnd, junk);
      collect(sel, rnd);
    join
  endtask

  task automatic pulse_reset_check(input string tag);
    reset = 1'b1;
    @(negedge clk);
    chk({tag, "_m_valid"}, longint'(mv[0]), 0);
    chk({tag, "_data_out"}, longint'(dout[0]), 0);
    chk({tag, "_overflow"}, longint'(ovf[0]), 0);
    chk({tag, "_s_ready_in_reset"}, longint'(sr[0]), 0);
    reset = 1'b0;
    @(negedge clk);
    chk({tag, "_s_ready_after_release"}, longint'(sr[0]), 1);
  endtask

  initial begin
    int w;
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    sv = '0;
    mr = '0;
    for (int s = 0; s < 3; s++) begin
      din[s] = '0;
      out_done[s] = 1'b0;
    end

    // Vector table: {dut select, A, x, expected y, expected overflow}.
    for (int k = 0; k < 5; k++) tbl[k] = '0;
    for (int i = 0; i < 9; i++) begin
      tbl[0].a[i] = 8'(i + 1);
      tbl[1].a[i] = 8'(-(i + 1));
      tbl[3].a[i] = (i >= 3 && i < 6) ? 8'd0 : 8'h80;
    end
    for (int j = 0; j < 3; j++) begin
      tbl[0].x[j] = 8'(j + 1);
      tbl[1].x[j] = 8'(3 - j);
      tbl[3].x[j] = 8'h80;
    end
    tbl[0].sel = 2'd0;
    tbl[0].y[0] = 16'd14;  tbl[0].y[1] = 16'd32;  tbl[0].y[2] = 16'd50;
    tbl[1].sel = 2'd0;
    tbl[1].y[0] = 16'(-10); tbl[1].y[1] = 16'(-28); tbl[1].y[2] = 16'(-46);
    tbl[2].sel = 2'd2;
    for (int i = 0; i < 8; i++) tbl[2].a[i] = 8'd2;
    for (int j = 0; j < 4; j++) tbl[2].x[j] = 8'(j + 1);
    tbl[2].y[0] = 16'd20;  tbl[2].y[1] = 16'd20;
    tbl[3].sel = 2'd0;
    tbl[3].y[0] = 16'(-16384); tbl[3].y[1] = 16'd0; tbl[3].y[2] = 16'(-16384);
    tbl[3].ov = 3'b101;
    tbl[4] = tbl[3];
    tbl[4].sel = 2'd1;
    tbl[4].y[0] = 16'd32767; tbl[4].y[1] = 16'd0; tbl[4].y[2] = 16'd32767;

    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("reset_s_ready_dut%0d", s), longint'(sr[s]), 0);
      chk($sformatf("reset_m_valid_dut%0d", s), longint'(mv[s]), 0);
      chk($sformatf("reset_data_out_dut%0d", s), longint'(dout[s]), 0);
      chk($sformatf("reset_overflow_dut%0d", s), longint'(ovf[s]), 0);
    end
    reset = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) chk($sformatf("release_s_ready_dut%0d", s), longint'(sr[s]), 1);

    // First two rows run back to back with random gaps and stalls.
    for (int k = 0; k < 5; k++) begin
      load_table(k);
      run_pass(int'(tbl[k].sel), (k < 2), 1'b1);
    end

    for (int p = 0; p < 12; p++) begin
      int sel;
      int total;
      sel = int'($urandom_range(0, 2));
      total = nm(sel) * nn(sel) + nn(sel);
      for (int i = 0; i < total; i++) begin
        if ($urandom_range(0, 3) == 0) in_buf[sel][i] = ($urandom_range(0, 1) == 1) ? 127 : -128;
        else in_buf[sel][i] = int'($urandom_range(0, 255)) - 128;
      end
      model(sel);
      run_pass(sel, 1'b1, 1'b1);
    end

    // Abort a pass in COMPUTE, then another while OUTPUT is stalled.
    load_table(0);
    send_inputs(0, 1'b0, 1'b0);
    @(negedge clk);
    chk("m_valid_in_compute", longint'(mv[0]), 0);
    pulse_reset_check("rst_compute");

    mr[0] = 1'b0;
    send_inputs(0, 1'b0, 1'b0);
    w = 0;
    while (!mv[0] && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("m_valid_before_output_reset", longint'(mv[0]), 1);
    @(negedge clk);
    chk("stalled_y0", longint'($signed(dout[0])), longint'(exp_y[0][0]));
    pulse_reset_check("rst_output");

    load_table(0);
    run_pass(0, 1'b0, 1'b1);
    load_table(1);
    run_pass(0, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mvm_stream.md
# mvm_stream

Parametrised streaming matrix-vector multiplier, generalising the fixed 3x3 multiplier to an M x N matrix with configurable data widths and a selectable wrap or saturate overflow mode. It accepts an M x N matrix and then an N-element vector over a valid/ready input stream. It computes y = A·x one multiply-accumulate per cycle and returns the M results over a valid/ready output stream, each with its own overflow flag. It sits between the input stream source and the downstream consumer in the neural-network layer datapath.

## Interface
- M, 3, number of matrix rows and output elements (>=1)
- N, 3, number of matrix columns and vector elements (>=1)
- IN_W, 8, signed input element width
- OUT_W, 16, signed accumulator/output width; must be >= 2*IN_W
- SAT, 0, overflow mode: 0 = two's-complement wrap, 1 = saturate
- clk  input  1  clock; all state changes on the rising edge
- reset  input  1  synchronous, active-high
- s_valid  input  1  input element valid
- s_ready  output  1  block can accept an input element
- data_in  input  IN_W  signed input element
- m_valid  output  1  output element valid
- m_ready  input  1  consumer accepts output element
- data_out  output  OUT_W  signed result y[r]
- overflow  output  1  overflow flag for the currently presented y[r]

## Operation
- Input transfer occurs when s_valid && s_ready on a clock edge. Output transfer occurs when m_valid && m_ready on a clock edge.
- Input order: the M*N elements of A in row-major order (A[0][0], A[0][1], …), then x[0]..x[N-1]. Total M*N+N transfers.
- FSM states:
  - LOAD_A: s_ready=1. Each transfer writes A at the next address. The transfer of element M*N-1 moves to LOAD_X.
  - LOAD_X: s_ready=1. The transfer of x[N-1] moves to COMPUTE.
  - COMPUTE: s_ready=0, m_valid=0. For r=0..M-1: clear the accumulator, accumulate A[r][c]*x[c] for c=0..N-1 in ascending c, then store y[r] and ovf[r] in the result buffer. After row M-1, move to OUTPUT.
  - OUTPUT: s_ready=0. Present y[k] and ovf[k] for k=0..M-1 in order. The transfer of k=M-1 moves to LOAD_A.
- Every matrix is freshly loaded; no data carries between passes.
- Arithmetic:
  - The product is the full 2*IN_W signed result, sign-extended to OUT_W.
  - Per add, overflow occurs when acc and the product have the same sign and the sum's sign differs.
  - ovf[r] is sticky across the row.
  - SAT=0: the accumulator wraps modulo 2^OUT_W.
  - SAT=1: on the first overflow the accumulator clamps to +2^(OUT_W-1)-1 or -2^(OUT_W-1), according to the operand sign, and stays frozen for the rest of the row.
- s_valid low during a load phase stalls loading with no state change. Input presented while s_ready=0 is ignored.
- m_ready low stalls OUTPUT. data_out, overflow and m_valid hold stable until the transfer.

## Timing
- Reset values: s_ready=0, m_valid=0, data_out=0, overflow=0, FSM in LOAD_A, all counters 0. s_ready goes to 1 on the first cycle after reset is released.
- Reset asserted in any state, including mid-compute or mid-output, aborts the pass. All outputs return to reset values on the next edge and partial data is discarded.
- Input accepts: up to one per cycle, with no bubble between the LOAD_A→LOAD_X boundary transfers.
- Compute latency: at most M*(N+2)+2 cycles from the final x accept to the first m_valid. Row results must not depend on pipeline fill; the bench checks order and values, not exact latency.
- Output: m_valid is asserted continuously through OUTPUT. With m_ready held high, one result transfers per cycle.
- After the final output transfer: m_valid=0 and s_ready=1 on the next cycle.
- overflow is valid only while m_valid=1. It is driven 0 otherwise.

## Test plan
- Defaults. A=1..9 row-major, x=1,2,3, m_ready=1 → outputs 14, 32, 50, all with overflow=0. Then s_ready=1 on the cycle after the last transfer.
- Random s_valid gaps and random m_ready (50%). Two back-to-back passes (second pass A=-1..-9, x=3,2,1) → 14,32,50 then -10,-28,-46, with no lost or duplicated transfers and data_out stable while stalled.
- M=2, N=4, A=all 2, x=1,2,3,4 → two outputs, both 20. Exactly 12 input transfers are accepted before s_ready drops.
- Overflow with all A and x elements = -128 (IN_W=8, OUT_W=16, N=3):
  - SAT=0 → each y = -16384, overflow=1.
  - SAT=1 → each y = 32767, overflow=1.
  - A row of zeros in the same matrix gives y=0, overflow=0.
- Reset asserted in COMPUTE and again during OUTPUT with m_ready=0 → m_valid=0, data_out=0, overflow=0 next cycle, s_ready=1 after release. A fresh pass then gives the correct results.
- Input driven while s_ready=0 (during COMPUTE and OUTPUT) → ignored, and the next pass results are unaffected.
